// File: rtl/cond_check_unit_pkg.sv
// Shared definitions for the condition-check path: ARM condition codes and
// NZCV flag bit positions. Also used by the branch unit through cond_eval.
package cond_check_unit_pkg;

  // Flag bit positions inside the status word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] cond_t;

  // ARM condition field encodings
  localparam cond_t COND_EQ = 4'd0;
  localparam cond_t COND_NE = 4'd1;
  localparam cond_t COND_CS = 4'd2;
  localparam cond_t COND_CC = 4'd3;
  localparam cond_t COND_MI = 4'd4;
  localparam cond_t COND_PL = 4'd5;
  localparam cond_t COND_VS = 4'd6;
  localparam cond_t COND_VC = 4'd7;
  localparam cond_t COND_HI = 4'd8;
  localparam cond_t COND_LS = 4'd9;
  localparam cond_t COND_GE = 4'd10;
  localparam cond_t COND_LT = 4'd11;
  localparam cond_t COND_GT = 4'd12;
  localparam cond_t COND_LE = 4'd13;
  localparam cond_t COND_AL = 4'd14;
  localparam cond_t COND_NV = 4'd15;

endpackage

// File: rtl/cond_check_unit_cond_eval.sv
// Combinational 16-way ARM condition evaluator: (cond, NZCV) -> pass.
module cond_eval
  import cond_check_unit_pkg::*;
#(
  parameter int LEN = 4
) (
  input  logic [3:0]     cond_i,
  input  logic [LEN-1:0] status_i,
  output logic           pass_o
);

  logic n, z, c, v;
  assign n = status_i[FLAG_N];
  assign z = status_i[FLAG_Z];
  assign c = status_i[FLAG_C];
  assign v = status_i[FLAG_V];

  // Decode the condition field against the current flags
  always_comb begin
    pass_o = 1'b0;
    unique case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_check_unit.sv
// Flag consumer: tracks in-flight flag writers, stalls dependent instructions
// in ID, drives the status register load strobe and registers the verdict.
module cond_check_unit
  import cond_check_unit_pkg::*;
#(
  parameter int LEN        = 4,
  parameter int PIPE_DEPTH = 3   // stages from leaving ID to the status write, >= 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           id_valid,
  input  logic [3:0]     id_cond,
  input  logic           id_s,
  input  logic [LEN-1:0] status,
  output logic           stall,
  output logic           flag_load,
  output logic           cond_valid,
  output logic           cond_pass
);

  logic [PIPE_DEPTH-1:0] s_pipe_q, s_pipe_d;
  logic                  valid_q, valid_d;
  logic                  pass_q, pass_d;
  logic                  issue;
  logic                  eval_pass;

  cond_eval #(.LEN(LEN)) u_eval (
    .cond_i   (id_cond),
    .status_i (status),
    .pass_o   (eval_pass)
  );

  // The oldest writer loads on this cycle's negedge, so flags are current
  // by the next posedge and it need not hold ID. AL never depends on flags.
  assign stall = id_valid & (id_cond != COND_AL) & (|s_pipe_q[PIPE_DEPTH-2:0]);
  assign issue = id_valid & ~stall;

  assign flag_load  = s_pipe_q[PIPE_DEPTH-1];
  assign cond_valid = valid_q;
  assign cond_pass  = pass_q;

  // Next-state: flush kills everything younger than EXE but lets the
  // oldest writer advance so its flag write still lands.
  always_comb begin
    s_pipe_d = {s_pipe_q[PIPE_DEPTH-2:0], issue & id_s};
    valid_d  = issue;
    pass_d   = issue & eval_pass;
    if (flush) begin
      s_pipe_d = {s_pipe_q[PIPE_DEPTH-2], {(PIPE_DEPTH-1){1'b0}}};
      valid_d  = 1'b0;
      pass_d   = 1'b0;
    end
  end

  // Writer tracker and ID/EXE verdict registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_pipe_q <= '0;
      valid_q  <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      s_pipe_q <= s_pipe_d;
      valid_q  <= valid_d;
      pass_q   <= pass_d;
    end
  end

endmodule

// File: doc/cond_check_unit.md
# cond_check_unit

Consumer side of the NZCV status register: evaluates the 4-bit ARM condition field of the instruction in ID against the current flags and tracks in-flight flag-setting instructions so no instruction reads stale flags. It sits between the ID stage and the status register. It generates the status register's `load` strobe, raises a stall while a flag writer is still in flight, and registers a pass/fail verdict into ID/EXE.

## Interface
Parameters:
- `LEN`, 4: status width, ordered N=[3], Z=[2], C=[1], V=[0].
- `PIPE_DEPTH`, 3: stages from leaving ID to the status write. Must be ≥2.

Ports:
- `clk`  in  1: clock. Posedge-triggered; the status register writes on negedge.
- `rst`  in  1: reset, asynchronous, active-high.
- `flush`  in  1: synchronous kill of every instruction younger than EXE.
- `id_valid`  in  1: the ID stage holds a real instruction.
- `id_cond`  in  4: condition field of the ID instruction.
- `id_s`  in  1: the ID instruction updates the flags (S bit).
- `status`  in  LEN: current flags from the status register.
- `stall`  out  1: combinational; ID must hold.
- `flag_load`  out  1: load strobe to the status register.
- `cond_valid`  out  1: registered; the instruction issued last cycle is valid.
- `cond_pass`  out  1: registered; that instruction's condition held.

## Operation
- **Writer tracker:** shift register `s_pipe[PIPE_DEPTH-1:0]`. Bit k set means a flag writer is k+1 stages past ID.
  - Each posedge: `s_pipe <= {s_pipe[PIPE_DEPTH-2:0], issue & id_s}`, where `issue = id_valid & ~stall`.
  - `flag_load = s_pipe[PIPE_DEPTH-1]`.
- **Hazard:** `stall = id_valid & (id_cond != 4'b1110) & |s_pipe[PIPE_DEPTH-2:0]`.
  - The oldest bit is excluded. The status register loads on the negedge of that same cycle, so flags are current by the next posedge.
  - AL instructions never stall.
- **Evaluation** (decimal cond code: function):
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z.
  - 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: !Z&(N==V). 13 LE: Z|(N!=V).
  - 14 AL: 1. 15 NV: 0.
- **Output register:**
  - `cond_valid <= issue`.
  - `cond_pass <= issue & eval(id_cond, status)`.
  - On stall, a bubble is issued: `cond_valid=0`, `cond_pass=0`, and a 0 is shifted into `s_pipe`.
- **Flush** (priority over issue):
  - `s_pipe[PIPE_DEPTH-2:0] <= 0`; the oldest bit shifts normally, so a writer already at EXE/WB still loads.
  - `cond_valid <= 0`, `cond_pass <= 0`.
- **Stalled S instruction:** its own S bit is not recorded until it issues.

## Timing
- Reset values: `s_pipe=0`, `flag_load=0`, `cond_valid=0`, `cond_pass=0`. `stall` is 0 whenever `s_pipe=0`.
- Verdict latency: 1 cycle after issue.
- `flag_load` asserts exactly PIPE_DEPTH cycles after a writer issues and lasts 1 cycle.
- Back-to-back S instructions: each sets its own bit; `flag_load` pulses on consecutive cycles.
- Dependent stall length after a writer issues at cycle t: stall for cycles t+1..t+PIPE_DEPTH-1. Issue at t+PIPE_DEPTH, evaluating the flags written at that cycle's negedge.
- Reset mid-operation clears all tracked writers immediately; no `flag_load` follows.
- `id_valid=0`: no stall, bubble issued, tracker still shifts.

## Structure
- Shared package holds:
  - condition-code constants `COND_EQ`..`COND_NV`;
  - flag bit indices `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`.
- One sub-module, `cond_eval`: purely combinational 16-way evaluator, `(cond, status) -> pass`. Reused by the branch unit.
- Top level holds the tracker, stall logic and output registers.

## Test plan
- **Reset, then cond decode:** `status=4'b0100` (Z=1); EQ then NE issued → `cond_pass` 1 then 0, `cond_valid` 1 both cycles, `stall` never asserted.
- **Full cond sweep:** all 16 conds × all 16 flag values against the table above; in particular `status=4'b1001` (N=V=1), GE → 1, LT → 0; NV → 0 for every status.
- **RAW on flags (PIPE_DEPTH=3):**
  - S instruction issues at t, EQ instruction waits at ID.
  - Required: `stall=1` at t+1 and t+2; `flag_load=1` at t+3; EQ issues at t+3 and its verdict reflects the newly written Z.
- **AL bypass:** same sequence with `id_cond=4'b1110` → no stall, `cond_pass=1` at t+2.
- **Flush:**
  - Two S instructions issued at t and t+1, `flush` at t+2.
  - Required: exactly one `flag_load` pulse (the older writer, at t+3); `cond_valid=0` at t+3.
- **Async reset mid-stall:** assert `rst` between edges while `stall=1` → `s_pipe`, `cond_valid` and `cond_pass` go to 0 immediately, `stall=0`, no later `flag_load`.
